// File: rtl/mul_controller.sv
// rtl/mul_controller.sv - control FSM for a shift-free add-and-decrement multiplier datapath
// Load strobes are decoded from state and inputs; abort gates every strobe in the cycle it is seen.
module mul_controller #(
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic              abort,
  input  logic              eqz,
  output logic              lda,
  output logic              ldb,
  output logic              clrp,
  output logic              ldp,
  output logic              decb,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      iter_cnt <= '0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:   if (start && !abort) state <= LOAD_A;
        LOAD_A: if (in_valid) state <= LOAD_B;
        LOAD_B: if (in_valid) begin
                  state    <= CALC;
                  iter_cnt <= '0;
                end
        CALC:   if (eqz) state <= DONE;
                else     iter_cnt <= iter_cnt + ITER_W'(1);
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // abort suppresses every strobe, including the done pulse, in the cycle it arrives
  assign lda  = (state == LOAD_A) && in_valid && !abort;
  assign ldb  = (state == LOAD_B) && in_valid && !abort;
  assign clrp = ldb;
  assign ldp  = (state == CALC) && !eqz && !abort;
  assign decb = ldp;
  assign busy = (state != IDLE);
  assign done = (state == DONE) && !abort;

endmodule

// File: tb/tb_mul_controller.sv
// tb/tb_mul_controller.sv - self-checking bench for mul_controller with a datapath model
// Expected results come from plain arithmetic: P = A*B, iterations = B, done at B+2 cycles.
module tb_mul_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        abort = 1'b0;
  logic        eqz;
  logic        lda, ldb, clrp, ldp, decb, busy, done;
  logic [15:0] iter_cnt;

  logic [15:0] bus = '0;
  logic [15:0] a_reg = '0;
  logic [15:0] b_cnt = '0;
  logic [15:0] p_reg = '0;
  logic        s_lda = 1'b0, s_ldb = 1'b0, s_clrp = 1'b0, s_ldp = 1'b0, s_decb = 1'b0;

  int ldp_tot = 0;
  int done_tot = 0;
  int overlap_tot = 0;
  int checks = 0;
  int errors = 0;

  mul_controller #(.ITER_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .abort(abort),
    .eqz(eqz), .lda(lda), .ldb(ldb), .clrp(clrp), .ldp(ldp), .decb(decb),
    .busy(busy), .done(done), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  assign eqz = (b_cnt == 16'd0);

  // strobes captured mid-cycle, then applied to the datapath model on the next rising edge
  always @(negedge clk) begin
    s_lda  = lda;
    s_ldb  = ldb;
    s_clrp = clrp;
    s_ldp  = ldp;
    s_decb = decb;
    if (ldp === 1'b1) ldp_tot++;
    if (done === 1'b1) done_tot++;
    if ((lda & ldb) | (lda & ldp) | (ldb & ldp)) overlap_tot++;
  end

  always @(posedge clk) begin
    if (s_lda) a_reg <= bus;
    if (s_ldb) b_cnt <= bus;
    else if (s_decb) b_cnt <= b_cnt - 16'd1;
    if (s_clrp) p_reg <= '0;
    else if (s_ldp) p_reg <= p_reg + a_reg;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int sa, input int sb,
                        input bit restart);
    int          c_ldp, c_done, k;
    bit          seen;
    logic [15:0] prod;
    prod   = a * b;
    c_ldp  = ldp_tot;
    c_done = done_tot;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_load_a", busy, 1);
    repeat (sa) begin
      in_valid = 1'b0;
      bus = 16'($urandom);
      @(negedge clk);
      check("stall_lda", lda, 0);
      check("stall_busy_a", busy, 1);
      tick();
    end
    bus = a;
    in_valid = 1'b1;
    @(negedge clk);
    check("lda_pulse", {lda, ldb, ldp}, 3'b100);
    tick();
    repeat (sb) begin
      in_valid = 1'b0;
      bus = 16'($urandom);
      @(negedge clk);
      check("stall_ldb", ldb, 0);
      check("stall_busy_b", busy, 1);
      tick();
    end
    bus = b;
    in_valid = 1'b1;
    @(negedge clk);
    check("ldb_clrp", {ldb, clrp, lda, ldp}, 4'b1100);
    tick();
    in_valid = 1'b0;
    bus = 16'($urandom);
    seen = 1'b0;
    k = 1;
    while (!seen && k <= int'(b) + 10) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else begin
        tick();
        start = restart && (k == 1);
        k++;
      end
    end
    start = 1'b0;
    check("done_latency", k, int'(b) + 2);
    tick();
    check("busy_after_done", busy, 0);
    check("iter_cnt", iter_cnt, b);
    check("product", p_reg, prod);
    check("ldp_count", ldp_tot - c_ldp, b);
    check("done_count", done_tot - c_done, 1);
    if (restart) begin
      repeat (4) tick();
      check("no_queued_start", busy, 0);
      check("single_done", done_tot - c_done, 1);
    end
  endtask

  initial begin
    int          d0;
    logic [15:0] held;

    #2;
    check("rst_outputs", {lda, ldb, clrp, ldp, decb, busy, done}, 7'b0);
    check("rst_iter", iter_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_op(16'd7, 16'd3, 0, 0, 1'b0);
    run_op(16'd9, 16'd0, 0, 0, 1'b0);
    run_op(16'd7, 16'd3, 5, 3, 1'b0);
    run_op(16'd2, 16'd4, 0, 0, 1'b1);
    check("iter_held_idle", iter_cnt, 4);

    // start and abort together in IDLE must stay idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", busy, 0);

    // reset in the middle of CALC after 4 iterations
    d0 = done_tot;
    start = 1'b1; tick(); start = 1'b0;
    bus = 16'd7; in_valid = 1'b1; tick();
    bus = 16'd10; tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("calc_iter4", iter_cnt, 4);
    rst_n = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    #1;
    check("mid_rst_outputs", {lda, ldb, clrp, ldp, decb, busy, done}, 7'b0);
    check("mid_rst_iter", iter_cnt, 0);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    rst_n = 1'b1;
    check("mid_rst_no_done", done_tot - d0, 0);
    run_op(16'd3, 16'd2, 0, 0, 1'b0);

    // abort in LOAD_B, with in_valid high
    held = iter_cnt;
    d0 = done_tot;
    start = 1'b1; tick(); start = 1'b0;
    bus = 16'd4; in_valid = 1'b1; tick();
    bus = 16'd3; abort = 1'b1;
    @(negedge clk);
    check("abort_ldb_gated", {ldb, clrp}, 2'b00);
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_ldb_idle", busy, 0);
    check("abort_ldb_iter", iter_cnt, held);

    // abort at iteration 2 of CALC
    start = 1'b1; tick(); start = 1'b0;
    bus = 16'd5; in_valid = 1'b1; tick();
    bus = 16'd6; tick();
    in_valid = 1'b0;
    repeat (2) tick();
    abort = 1'b1;
    @(negedge clk);
    check("abort_calc_gated", {ldp, decb, done}, 3'b000);
    tick();
    abort = 1'b0;
    check("abort_calc_idle", busy, 0);
    repeat (8) tick();
    check("abort_calc_iter", iter_cnt, 2);
    check("abort_no_done", done_tot - d0, 0);

    // abort in IDLE is harmless; the next start is accepted
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_idle", busy, 0);

    for (int i = 0; i < 20; i++) begin
      run_op(16'($urandom), 16'($urandom_range(0, 20)), $urandom_range(0, 3),
             $urandom_range(0, 3), 1'b0);
    end

    check("no_strobe_overlap", overlap_tot, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_controller.md
MUL_CONTROLLER -- requirements
Module: mul_controller

Interface
REQ-001: Parameter ITER_W, default 16, width of the iteration counter; it matches the datapath operand width.
REQ-002: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: start  input  1  single-cycle request to begin a multiplication; sampled in IDLE only.
REQ-005: in_valid  input  1  the operand on the shared datapath bus is valid this cycle.
REQ-006: abort  input  1  synchronous cancel of the operation in progress.
REQ-007: eqz  input  1  datapath flag, high when the B counter equals zero.
REQ-008: lda  output  1  load A register from the bus.
REQ-009: ldb  output  1  load B counter from the bus.
REQ-010: clrp  output  1  clear the product register.
REQ-011: ldp  output  1  load the product register with P+A.
REQ-012: decb  output  1  decrement the B counter.
REQ-013: busy  output  1  high in every state except IDLE.
REQ-014: done  output  1  one-cycle completion pulse.
REQ-015: iter_cnt  output  ITER_W  number of add iterations performed in the current or last operation.

Function
REQ-016: The FSM SHALL have states IDLE, LOAD_A, LOAD_B, CALC and DONE, encoded in a registered state vector.
REQ-017: IDLE SHALL go to LOAD_A on start=1; otherwise it SHALL stay in IDLE.
REQ-018: LOAD_A SHALL assert lda combinationally while in_valid=1 and SHALL go to LOAD_B on that edge; it SHALL wait indefinitely while in_valid=0.
REQ-019: LOAD_B SHALL assert ldb and clrp together while in_valid=1, SHALL clear iter_cnt on that edge, and SHALL go to CALC; it SHALL wait while in_valid=0.
REQ-020: In CALC with eqz=0, the block SHALL assert ldp and decb in the same cycle, increment iter_cnt by 1, and stay in CALC.
REQ-021: In CALC with eqz=1, the block SHALL assert neither ldp nor decb and SHALL go to DONE.
REQ-022: DONE SHALL assert done for exactly one cycle and SHALL return to IDLE unconditionally.
REQ-023: Latency from the LOAD_B in_valid edge to done high SHALL be B+2 cycles for operand B: B CALC add cycles, one CALC exit cycle, then DONE.
REQ-024: B=0 SHALL give zero ldp pulses, iter_cnt=0, and done 2 cycles after the LOAD_B edge.
REQ-025: iter_cnt SHALL wrap modulo 2^ITER_W; it cannot overflow when ITER_W equals the operand width.
REQ-026: start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027: abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse, all control outputs low in that cycle, and iter_cnt held.
REQ-028: abort has priority over in_valid and eqz; abort in IDLE has no effect, and start and abort together in IDLE SHALL keep IDLE.
REQ-029: lda, ldb, clrp, ldp and decb SHALL be decoded from state and inputs only, and no two of {lda, ldb, ldp} SHALL be high in the same cycle.
REQ-030: iter_cnt SHALL hold its value in IDLE so software can read the last result.

Reset
REQ-031: rst_n=0 SHALL immediately force IDLE, iter_cnt=0, and busy, done, lda, ldb, clrp, ldp and decb all to 0, independent of clk.
REQ-032: Reset asserted mid-CALC SHALL abandon the operation without a done pulse; after release the block SHALL accept a new start on the first edge.
REQ-033: Reset release SHALL be synchronised by the integrator; the block SHALL tolerate any input values while rst_n=0.

Verification
REQ-034: start; bus A=7, then B=3, each with in_valid -> lda 1 cycle, ldb+clrp 1 cycle, ldp/decb 3 consecutive cycles, done 5 cycles after the ldb edge, iter_cnt=3, datapath P=21.
REQ-035: start; A=9, B=0 -> no ldp/decb, done 2 cycles after the ldb edge, iter_cnt=0, P=0.
REQ-036: start; in_valid held low 5 cycles in LOAD_A and 3 cycles in LOAD_B -> no lda/ldb during the stall, busy=1 throughout, result as in REQ-034.
REQ-037: start pulsed again during CALC (A=2, B=4) -> ignored, exactly one done, iter_cnt=4, busy low the cycle after done.
REQ-038: rst_n low for 1 cycle during CALC (B=10, after 4 iterations) -> outputs 0 immediately, iter_cnt=0, no done; next start with A=3, B=2 completes normally with P=6.
REQ-039: abort in LOAD_B and again at iteration 2 of CALC -> IDLE next edge, no done, iter_cnt=2 held after the second abort.
